spi_burst_arbiter: RTL and testbench



---
 rtl/spi_burst_arbiter.sv | 142 ++++++++++++++
 tb/tb_spi_burst_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_arbiter.sv
// spi_burst_arbiter: shares one byte-level SPI master among NUM_CLIENTS
// burst requesters, round-robin per burst, with a per-client chip select.
module spi_burst_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int CS_GAP      = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] c_tx_data,
  input  logic [NUM_CLIENTS-1:0]            c_tx_valid,
  input  logic [NUM_CLIENTS-1:0]            c_tx_last,
  output logic [NUM_CLIENTS-1:0]            c_tx_ready,
  output logic [DATA_WIDTH-1:0]             c_rx_data,
  output logic [NUM_CLIENTS-1:0]            c_rx_valid,
  output logic [DATA_WIDTH-1:0]             m_tx_data,
  output logic                              m_tx_valid,
  input  logic                              m_tx_ready,
  input  logic [DATA_WIDTH-1:0]             m_rx_data,
  input  logic                              m_rx_valid,
  output logic [NUM_CLIENTS-1:0]            cs_n,
  output logic [$clog2(NUM_CLIENTS)-1:0]    grant_id,
  output logic                              busy
);

  localparam int GW = $clog2(NUM_CLIENTS);
  localparam int CW = $clog2(CS_GAP + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]             r_state;
  logic [GW-1:0]          r_grant;
  logic [GW-1:0]          r_last;
  logic                   r_lflag;
  logic [CW-1:0]          r_cnt;
  logic [NUM_CLIENTS-1:0] r_cs_n;
  logic [DATA_WIDTH-1:0]  r_mtx_data;
  logic                   r_mtx_valid;
  logic [DATA_WIDTH-1:0]  r_rx_data;
  logic [NUM_CLIENTS-1:0] r_rx_valid;

  logic                   w_found;
  logic [GW-1:0]          w_win;
  logic [GW-1:0]          w_idx;
  logic [NUM_CLIENTS-1:0] w_win_oh;
  logic [NUM_CLIENTS-1:0] w_sel;
  logic [DATA_WIDTH-1:0]  w_byte;
  logic                   w_vld;
  logic                   w_last;
  logic                   w_xfer;

  // Scan starts one past the last burst owner so every requester
  // is reached within NUM_CLIENTS bursts.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_CLIENTS; i++) begin
      w_idx = GW'((int'(r_last) + i) % NUM_CLIENTS);
      if (!w_found && c_tx_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_oh = NUM_CLIENTS'(1) << w_win;
  assign w_sel    = NUM_CLIENTS'(1) << r_grant;
  assign w_byte   = c_tx_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
  assign w_vld    = c_tx_valid[r_grant];
  assign w_last   = c_tx_last[r_grant];
  assign w_xfer   = (r_state == S_ISSUE) && m_tx_ready && w_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_last      <= GW'(NUM_CLIENTS - 1);
      r_lflag     <= 1'b0;
      r_cnt       <= '0;
      r_cs_n      <= '1;
      r_mtx_data  <= '0;
      r_mtx_valid <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= '0;
    end else begin
      r_mtx_valid <= 1'b0;
      r_rx_valid  <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_win;
            r_cs_n  <= ~w_win_oh;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: r_state <= S_ISSUE;
        S_ISSUE: begin
          if (w_xfer) begin
            r_mtx_data  <= w_byte;
            r_lflag     <= w_last;
            r_mtx_valid <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (m_rx_valid) begin
            r_rx_data  <= m_rx_data;
            r_rx_valid <= w_sel;
            if (r_lflag) begin
              r_state <= S_GAP;
              r_cs_n  <= '1;
              r_last  <= r_grant;
              r_cnt   <= CW'(CS_GAP);
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_GAP: begin
          if (r_cnt <= CW'(1)) r_state <= S_IDLE;
          else r_cnt <= r_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign c_tx_ready = (r_state == S_ISSUE && m_tx_ready) ? w_sel : '0;
  assign c_rx_data  = r_rx_data;
  assign c_rx_valid = r_rx_valid;
  assign m_tx_data  = r_mtx_data;
  assign m_tx_valid = r_mtx_valid;
  assign cs_n       = r_cs_n;
  assign grant_id   = r_grant;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// tb_spi_burst_arbiter: client queues, SPI master/slave model (~MOSI echo)
// and a round-robin burst reference model.
module tb_spi_burst_arbiter;

  localparam int NC  = 4;
  localparam int DW  = 8;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC*DW-1:0] c_tx_data = '0;
  logic [NC-1:0]    c_tx_valid = '0;
  logic [NC-1:0]    c_tx_last = '0;
  logic [NC-1:0]    c_tx_ready;
  logic [DW-1:0]    c_rx_data;
  logic [NC-1:0]    c_rx_valid;
  logic [DW-1:0]    m_tx_data;
  logic             m_tx_valid;
  logic             m_tx_ready = 1'b1;
  logic [DW-1:0]    m_rx_data = '0;
  logic             m_rx_valid = 1'b0;
  logic [NC-1:0]    cs_n;
  logic [1:0]       grant_id;
  logic             busy;

  spi_burst_arbiter #(.NUM_CLIENTS(NC), .DATA_WIDTH(DW), .CS_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_tx_data(c_tx_data), .c_tx_valid(c_tx_valid),
    .c_tx_last(c_tx_last), .c_tx_ready(c_tx_ready),
    .c_rx_data(c_rx_data), .c_rx_valid(c_rx_valid),
    .m_tx_data(m_tx_data), .m_tx_valid(m_tx_valid),
    .m_tx_ready(m_tx_ready), .m_rx_data(m_rx_data),
    .m_rx_valid(m_rx_valid), .cs_n(cs_n),
    .grant_id(grant_id), .busy(busy)
  );

  int vec = 0;
  int errs = 0;

  logic [8:0] cbuf [NC][64];
  int cwr [NC];
  int crd [NC];
  bit hold [NC];
  bit rnd_stall = 0;
  int lat_max = 3;

  logic [7:0] mm_byte;
  int mm_cnt = 0;
  logic [NC-1:0] hs = '0;
  bit mrx_drv = 0;

  int g_log[$];
  int g_tick[$];
  logic [11:0] rx_log[$];
  logic [7:0] tx_log[$];
  int gap_log[$];
  int tickn = 0;
  int inv_err = 0;
  int gap_run = 0;
  int idle_tick = 0;
  bit prev_high = 1;
  bit prev_busy = 0;

  task automatic enq(input int c, input logic [7:0] b, input bit l);
    cbuf[c][cwr[c]] = {l, b};
    cwr[c]++;
  endtask

  task automatic clear_logs();
    g_log.delete(); g_tick.delete(); rx_log.delete();
    tx_log.delete(); gap_log.delete();
    inv_err = 0;
    for (int c = 0; c < NC; c++) begin
      cwr[c] = 0; crd[c] = 0; hold[c] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_logs();
    rnd_stall = 0; mm_cnt = 0; hs = '0; mrx_drv = 0;
    m_tx_ready = 1'b1; m_rx_valid = 1'b0;
    c_tx_valid = '0; c_tx_last = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_high = 1; prev_busy = 0; gap_run = 0;
  endtask

  // One clock: drive at negedge, sample handshakes just before the edge,
  // observe outputs just after it.
  task automatic tick();
    bit st;
    int gi;
    for (int c = 0; c < NC; c++) if (hs[c]) crd[c]++;
    m_rx_valid = 1'b0;
    if (mm_cnt > 0) begin
      mm_cnt--;
      if (mm_cnt == 0) begin
        m_rx_valid = 1'b1;
        m_rx_data  = ~mm_byte;
        m_tx_ready = 1'b1;
      end
    end
    mrx_drv = m_rx_valid;
    for (int c = 0; c < NC; c++) begin
      st = hold[c] || (rnd_stall && !cs_n[c] && $urandom_range(0, 3) == 0);
      if (crd[c] < cwr[c]) begin
        c_tx_valid[c] = !st;
        c_tx_data[c*DW +: DW] = cbuf[c][crd[c]][7:0];
        c_tx_last[c] = cbuf[c][crd[c]][8];
      end else begin
        c_tx_valid[c] = 1'b0;
        c_tx_last[c] = 1'b0;
      end
    end
    #4;
    hs = c_tx_valid & c_tx_ready;
    @(posedge clk);
    #1;
    tickn++;
    if (m_tx_valid) begin
      tx_log.push_back(m_tx_data);
      mm_byte = m_tx_data;
      mm_cnt = $urandom_range(1, lat_max);
      m_tx_ready = 1'b0;
    end
    if (m_tx_valid !== (|hs)) inv_err++;
    if ((|c_rx_valid) !== mrx_drv) inv_err++;
    if ($countones(c_rx_valid) > 1) inv_err++;
    if ($countones(~cs_n) > 1) inv_err++;
    if ($countones(c_tx_ready) > 1) inv_err++;
    if ((c_tx_ready & cs_n) != '0) inv_err++;
    gi = 0;
    for (int c = 0; c < NC; c++) if (c_rx_valid[c]) gi = c;
    if (|c_rx_valid) rx_log.push_back({4'(gi), c_rx_data});
    gi = 0;
    for (int c = 0; c < NC; c++) if (!cs_n[c]) gi = c;
    if (prev_high && cs_n != '1) begin
      g_log.push_back(gi);
      g_tick.push_back(tickn);
    end
    if (cs_n == '1 && busy) gap_run++;
    if (prev_busy && !busy) begin
      gap_log.push_back(gap_run);
      idle_tick = tickn;
    end
    if (cs_n != '1) gap_run = 0;
    prev_high = (cs_n == '1);
    prev_busy = busy;
    @(negedge clk);
  endtask

  task automatic run_idle(input int maxc, output bit to);
    bit pend;
    to = 1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      pend = 0;
      for (int c = 0; c < NC; c++) if (crd[c] < cwr[c]) pend = 1;
      if (!pend && hs == '0 && mm_cnt == 0 && !m_rx_valid && !busy) begin
        to = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vec++; if (cs_n !== 4'hF) begin errs++; $display("FAIL rst_cs_n got %h want f", cs_n); end
    vec++; if (m_tx_valid !== 1'b0) begin errs++; $display("FAIL rst_mtxv got %b want 0", m_tx_valid); end
    vec++; if (m_tx_data !== 8'h00) begin errs++; $display("FAIL rst_mtxd got %h want 00", m_tx_data); end
    vec++; if (c_rx_valid !== 4'h0) begin errs++; $display("FAIL rst_crxv got %h want 0", c_rx_valid); end
    vec++; if (c_rx_data !== 8'h00) begin errs++; $display("FAIL rst_crxd got %h want 00", c_rx_data); end
    vec++; if (grant_id !== 2'd0) begin errs++; $display("FAIL rst_grant got %0d want 0", grant_id); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
    vec++; if (c_tx_ready !== 4'h0) begin errs++; $display("FAIL rst_ready got %h want 0", c_tx_ready); end
    do_reset();
    tick(); tick();
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    bit to;
    int t0;
    clear_logs();
    enq(0, 8'hA5, 1);
    t0 = tickn + 1;
    run_idle(200, to);
    vec++; if (to) begin errs++; $display("FAIL single_timeout got 1 want 0"); end
    vec++; if (g_log.size() !== 1 || g_log[0] !== 0) begin errs++; $display("FAIL single_grant got n=%0d want client 0 once", g_log.size()); end
    vec++; if (g_tick.size() < 1 || g_tick[0] !== t0) begin errs++; $display("FAIL single_cs_latency got tick %0d want %0d", g_tick.size() ? g_tick[0] : -1, t0); end
    vec++; if (tx_log.size() !== 1 || tx_log[0] !== 8'hA5) begin errs++; $display("FAIL single_mtx got n=%0d want one A5", tx_log.size()); end
    vec++; if (rx_log.size() !== 1 || rx_log[0] !== 12'h05A) begin errs++; $display("FAIL single_rx got n=%0d want one 0/5a", rx_log.size()); end
    vec++; if (gap_log.size() !== 1 || gap_log[0] !== GAP) begin errs++; $display("FAIL single_gap got %0d want %0d", gap_log.size() ? gap_log[0] : -1, GAP); end
    vec++; if (inv_err !== 0) begin errs++; $display("FAIL single_invariants got %0d want 0", inv_err); end
  endtask

  task automatic test_three_byte();
    bit to;
    logic [11:0] exp [3];
    exp[0] = 12'h2FC; exp[1] = 12'h2EF; exp[2] = 12'h2DF;
    clear_logs();
    enq(2, 8'h03, 0); enq(2, 8'h10, 0); enq(2, 8'h20, 1);
    run_idle(300, to);
    vec++; if (to) begin errs++; $display("FAIL three_timeout got 1 want 0"); end
    vec++; if (g_log.size() !== 1 || g_log[0] !== 2) begin errs++; $display("FAIL three_cs_continuous got %0d grants want 1 of client 2", g_log.size()); end
    vec++; if (rx_log.size() !== 3) begin errs++; $display("FAIL three_rx_count got %0d want 3", rx_log.size()); end
    for (int i = 0; i < 3 && i < rx_log.size(); i++) begin
      vec++; if (rx_log[i] !== exp[i]) begin errs++; $display("FAIL three_rx%0d got %h want %h", i, rx_log[i], exp[i]); end
    end
    vec++; if (inv_err !== 0) begin errs++; $display("FAIL three_invariants got %0d want 0", inv_err); end
  endtask

  task automatic test_simultaneous();
    bit to;
    do_reset();
    enq(1, 8'h11, 1);
    enq(3, 8'h33, 1);
    run_idle(300, to);
    vec++; if (to) begin errs++; $display("FAIL simul_timeout got 1 want 0"); end
    vec++; if (g_log.size() !== 2 || g_log[0] !== 1 || g_log[1] !== 3) begin errs++; $display("FAIL simul_order got n=%0d want 1,3", g_log.size()); end
    vec++; if (rx_log.size() !== 2 || rx_log[0] !== 12'h1EE || rx_log[1] !== 12'h3CC) begin errs++; $display("FAIL simul_rx got n=%0d want 1/ee,3/cc", rx_log.size()); end
  endtask

  task automatic test_stall();
    bit to;
    int lows;
    int txn;
    logic [7:0] b0, b1;
    b0 = 8'($urandom); b1 = 8'($urandom);
    clear_logs();
    enq(0, b0, 0); enq(0, b1, 1);
    to = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hs[0]) begin to = 0; break; end
    end
    vec++; if (to) begin errs++; $display("FAIL stall_first_byte got none want transfer"); end
    hold[0] = 1;
    lows = 0;
    txn = tx_log.size();
    repeat (20) begin
      tick();
      if (cs_n[0] === 1'b0) lows++;
    end
    vec++; if (lows !== 20) begin errs++; $display("FAIL stall_cs_held got %0d want 20", lows); end
    vec++; if (tx_log.size() !== txn) begin errs++; $display("FAIL stall_no_issue got %0d want %0d", tx_log.size(), txn); end
    hold[0] = 0;
    run_idle(300, to);
    vec++; if (to) begin errs++; $display("FAIL stall_timeout got 1 want 0"); end
    vec++; if (rx_log.size() !== 2 || rx_log[0] !== {4'd0, ~b0} || rx_log[1] !== {4'd0, ~b1}) begin errs++; $display("FAIL stall_rx got n=%0d want 2 bytes", rx_log.size()); end
    vec++; if (g_log.size() !== 1) begin errs++; $display("FAIL stall_one_burst got %0d want 1", g_log.size()); end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_logs();
    enq(1, 8'h5C, 0); enq(1, 8'h6D, 1);
    to = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_log.size() > 0) begin to = 0; break; end
    end
    vec++; if (to) begin errs++; $display("FAIL rmid_no_issue got none want m_tx_valid"); end
    rst_n = 1'b0;
    #1;
    vec++; if (cs_n !== 4'hF) begin errs++; $display("FAIL rmid_cs got %h want f", cs_n); end
    vec++; if (m_tx_valid !== 1'b0) begin errs++; $display("FAIL rmid_mtxv got %b want 0", m_tx_valid); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got %b want 0", busy); end
    do_reset();
    enq(1, 8'h01, 1);
    enq(0, 8'h02, 1);
    run_idle(300, to);
    vec++; if (to) begin errs++; $display("FAIL rmid_timeout got 1 want 0"); end
    vec++; if (g_log.size() !== 2 || g_log[0] !== 0 || g_log[1] !== 1) begin errs++; $display("FAIL rmid_order got n=%0d want 0,1", g_log.size()); end
  endtask

  task automatic test_gap_holdoff();
    bit to;
    int hits;
    clear_logs();
    enq(0, 8'h77, 1);
    to = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy && cs_n == '1) begin to = 0; break; end
    end
    vec++; if (to) begin errs++; $display("FAIL gap_not_reached got none want GAP"); end
    enq(1, 8'h88, 1);
    hits = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      tick();
      if (busy && cs_n == '1 && c_tx_ready[1]) hits++;
    end
    vec++; if (hits !== 0) begin errs++; $display("FAIL gap_ready got %0d want 0", hits); end
    run_idle(300, to);
    vec++; if (to) begin errs++; $display("FAIL gap_timeout got 1 want 0"); end
    vec++; if (g_log.size() !== 2 || g_log[1] !== 1) begin errs++; $display("FAIL gap_order got n=%0d want 0,1", g_log.size()); end
    vec++; if (g_tick.size() < 2 || g_tick[1] !== gap_log[0] * 0 + idle_first(gap_log.size())) begin errs++; $display("FAIL gap_grant_tick got %0d want first idle+1", g_tick.size() > 1 ? g_tick[1] : -1); end
  endtask

  int idle_ticks[$];
  function automatic int idle_first(input int n);
    return (idle_ticks.size() > 0) ? idle_ticks[0] + 1 : -1 + n * 0;
  endfunction
  always @(negedge busy) if (rst_n) idle_ticks.push_back(tickn + 1);

  task automatic test_round_robin();
    bit to;
    int nb [NC];
    int blen [NC][3];
    logic [7:0] bb [NC][12];
    int rem [NC];
    int bi [NC];
    int bp [NC];
    int eg[$];
    logic [11:0] erx[$];
    int last, tot, nburst, k, c, badg, badr, badgap;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      rnd_stall = 1;
      lat_max = 4;
      tot = 0; nburst = 0;
      eg.delete(); erx.delete();
      for (int cc = 0; cc < NC; cc++) begin
        nb[cc] = $urandom_range(1, 3);
        nburst += nb[cc];
        k = 0;
        for (int j = 0; j < nb[cc]; j++) begin
          blen[cc][j] = $urandom_range(1, 4);
          for (int b = 0; b < blen[cc][j]; b++) begin
            bb[cc][k] = 8'($urandom);
            enq(cc, bb[cc][k], b == blen[cc][j] - 1);
            k++; tot++;
          end
        end
        rem[cc] = nb[cc]; bi[cc] = 0; bp[cc] = 0;
      end
      last = NC - 1;
      repeat (nburst) begin
        c = 0;
        for (int i = 1; i <= NC; i++) begin
          c = (last + i) % NC;
          if (rem[c] > 0) break;
        end
        eg.push_back(c);
        for (int j = 0; j < blen[c][bi[c]]; j++) begin
          erx.push_back({4'(c), ~bb[c][bp[c]]});
          bp[c]++;
        end
        bi[c]++; rem[c]--; last = c;
      end
      run_idle(5000, to);
      rnd_stall = 0;
      vec++; if (to) begin errs++; $display("FAIL rr%0d_timeout got 1 want 0", r); end
      vec++; if (g_log.size() !== eg.size()) begin errs++; $display("FAIL rr%0d_grant_count got %0d want %0d", r, g_log.size(), eg.size()); end
      badg = 0;
      for (int i = 0; i < eg.size() && i < g_log.size(); i++) if (g_log[i] !== eg[i]) badg++;
      vec++; if (badg !== 0) begin errs++; $display("FAIL rr%0d_grant_order got %0d wrong want 0", r, badg); end
      vec++; if (rx_log.size() !== erx.size()) begin errs++; $display("FAIL rr%0d_rx_count got %0d want %0d", r, rx_log.size(), erx.size()); end
      badr = 0;
      for (int i = 0; i < erx.size() && i < rx_log.size(); i++) if (rx_log[i] !== erx[i]) badr++;
      vec++; if (badr !== 0) begin errs++; $display("FAIL rr%0d_rx_data got %0d wrong want 0", r, badr); end
      vec++; if (tx_log.size() !== tot) begin errs++; $display("FAIL rr%0d_tx_count got %0d want %0d", r, tx_log.size(), tot); end
      badgap = 0;
      foreach (gap_log[i]) if (gap_log[i] !== GAP) badgap++;
      vec++; if (badgap !== 0 || gap_log.size() !== eg.size()) begin errs++; $display("FAIL rr%0d_gap got %0d bad of %0d want 0 of %0d", r, badgap, gap_log.size(), eg.size()); end
      vec++; if (inv_err !== 0) begin errs++; $display("FAIL rr%0d_invariants got %0d want 0", r, inv_err); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_byte();
    test_simultaneous();
    test_stall();
    test_reset_mid();
    idle_ticks.delete();
    test_gap_holdoff();
    test_round_robin();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got expired want finish");
    $fatal(1);
  end

endmodule
